// File: rtl/dvp_frame_monitor.sv
// DVP stream geometry checker: measures line width / frame height per frame and flags mismatches.
// Optional pixel checksum is built when DVP_MON_CHECKSUM_EN is defined.
module dvp_frame_monitor #(
    parameter int unsigned BITS   = 8,
    parameter int unsigned H_DISP = 5,
    parameter int unsigned V_DISP = 5,
    parameter bit          V_POL  = 1'b1
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            href,
    input  logic            vsync,
    input  logic [BITS-1:0] data,
    input  logic            clr_err,
    output logic            frame_done,
    output logic [15:0]     frame_cnt,
    output logic [15:0]     line_width,
    output logic [15:0]     frame_height,
    output logic            err_width,
    output logic            err_height,
    output logic            err_sync,
    output logic [31:0]     checksum
);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ACTIVE} state_t;

    localparam logic [15:0] H_EXP = 16'(H_DISP);
    localparam logic [15:0] V_EXP = 16'(V_DISP);

    state_t      state_q, state_d;
    logic        href_q, href_d;
    logic        vsync_q, vsync_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] line_width_q, line_width_d;
    logic [15:0] frame_height_q, frame_height_d;
    logic        err_width_q, err_width_d;
    logic        err_height_q, err_height_d;
    logic        err_sync_q, err_sync_d;

    logic        vs_act, vs_rise, h_fall;
    logic        set_width, set_height, set_sync;
    logic        acc_clear, acc_add, finalize;
    logic [15:0] line_cnt_inc, fin_height;

    always_comb begin
        vs_act       = (vsync == V_POL);
        vs_rise      = vs_act && (vsync_q != V_POL);
        h_fall       = href_q && !href;
        line_cnt_inc = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;

        state_d        = state_q;
        href_d         = href;
        vsync_d        = vsync;
        pix_cnt_d      = pix_cnt_q;
        line_cnt_d     = line_cnt_q;
        frame_done_d   = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        line_width_d   = line_width_q;
        frame_height_d = frame_height_q;
        fin_height     = line_cnt_q;
        set_width      = 1'b0;
        set_height     = 1'b0;
        set_sync       = href && vs_act && (state_q != ST_IDLE);
        acc_clear      = 1'b0;
        acc_add        = 1'b0;
        finalize       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vs_rise) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!vs_act) begin
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    acc_clear  = 1'b1;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (href) begin
                    acc_add = 1'b1;
                    if (pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
                end
                if (h_fall) begin
                    line_width_d = pix_cnt_q;
                    set_width    = (pix_cnt_q != H_EXP);
                    line_cnt_d   = line_cnt_inc;
                    pix_cnt_d    = '0;
                end
                // A line closing on the vs_rise edge still belongs to the finishing frame.
                if (vs_rise) begin
                    fin_height     = h_fall ? line_cnt_inc : line_cnt_q;
                    frame_height_d = fin_height;
                    set_height     = (fin_height != V_EXP);
                    frame_cnt_d    = frame_cnt_q + 16'd1;
                    frame_done_d   = 1'b1;
                    finalize       = 1'b1;
                    state_d        = ST_SYNC;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_width_d  = set_width  | (err_width_q  & ~clr_err);
        err_height_d = set_height | (err_height_q & ~clr_err);
        err_sync_d   = set_sync   | (err_sync_q   & ~clr_err);
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            href_q         <= 1'b0;
            vsync_q        <= ~V_POL;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            frame_done_q   <= 1'b0;
            frame_cnt_q    <= '0;
            line_width_q   <= '0;
            frame_height_q <= '0;
            err_width_q    <= 1'b0;
            err_height_q   <= 1'b0;
            err_sync_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            href_q         <= href_d;
            vsync_q        <= vsync_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            frame_done_q   <= frame_done_d;
            frame_cnt_q    <= frame_cnt_d;
            line_width_q   <= line_width_d;
            frame_height_q <= frame_height_d;
            err_width_q    <= err_width_d;
            err_height_q   <= err_height_d;
            err_sync_q     <= err_sync_d;
        end
    end

`ifdef DVP_MON_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        acc_d      = acc_q;
        checksum_d = checksum_q;
        if (acc_clear)    acc_d = '0;
        else if (acc_add) acc_d = acc_q + 32'(data);
        // Latched value covers pixels up to, not including, the vs_rise cycle.
        if (finalize)     checksum_d = acc_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            checksum_q <= '0;
        end else begin
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_acc;
    assign unused_acc = ^{data, acc_clear, acc_add, finalize};
    assign checksum   = '0;
`endif

    assign frame_done   = frame_done_q;
    assign frame_cnt    = frame_cnt_q;
    assign line_width   = line_width_q;
    assign frame_height = frame_height_q;
    assign err_width    = err_width_q;
    assign err_height   = err_height_q;
    assign err_sync     = err_sync_q;

endmodule

// File: doc/dvp_frame_monitor.md
# dvp_frame_monitor

Synthesizable checker placed directly downstream of a DVP source, such as the file-driven DVP generator or a sensor front end. It samples `href`/`vsync`/`data` on `pclk` and measures active line width and frame height for every frame. It compares both against the configured geometry and reports per-frame results and sticky error flags. It sits in parallel with the file dump stage, so a bench or on-chip debug register can confirm stream geometry before data enters the ISP.

## Interface
- `BITS`, 8: pixel data width.
- `H_DISP`, 5: expected active pixels per line.
- `V_DISP`, 5: expected active lines per frame.
- `V_POL`, 1: active level of `vsync`.
- `pclk` input 1: pixel clock; the only clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `href` input 1: line valid, active high.
- `vsync` input 1: frame sync, active level `V_POL`.
- `data` input BITS: pixel, valid when `href`=1.
- `clr_err` input 1: one-cycle clear of sticky errors.
- `frame_done` output 1: one-cycle pulse when a frame is finalized.
- `frame_cnt` output 16: number of finalized frames; wraps.
- `line_width` output 16: pixel count of the most recently completed line.
- `frame_height` output 16: line count of the last finalized frame.
- `err_width` output 1: sticky; some line width ≠ `H_DISP`.
- `err_height` output 1: sticky; some frame height ≠ `V_DISP`.
- `err_sync` output 1: sticky; `href`=1 sampled while `vsync` is active.
- `checksum` output 32: pixel sum of the last finalized frame (see Configuration).

## Operation
- Registered previous samples: `href_q`, `vsync_q`.
  - vs_rise: `vsync`==`V_POL` && `vsync_q`!=`V_POL`.
  - h_fall: `href_q` && !`href`.
- FSM states:
  - IDLE: after reset. Waits for vs_rise, then goes to SYNC. The partial frame after reset is discarded.
  - SYNC: waits for `vsync` inactive; then clears `pix_cnt`, `line_cnt` and the checksum accumulator and goes to ACTIVE.
  - ACTIVE: counts pixels and lines. On vs_rise: finalize the frame, then go to SYNC.
- `pix_cnt`: increments on every cycle with `href`=1.
- On h_fall:
  - `line_width` <= `pix_cnt`; set `err_width` if `pix_cnt` != `H_DISP`.
  - `line_cnt`++; `pix_cnt` <= 0, or <= 1 if `href`=1 on that edge (not possible for a falling edge).
- Finalize:
  - `frame_height` <= `line_cnt`; set `err_height` if `line_cnt` != `V_DISP`.
  - `frame_cnt`++; `checksum` <= accumulator; `frame_done` <= 1 for one cycle.
- `pix_cnt` and `line_cnt` saturate at 16'hFFFF; no wrap.
- `err_sync`: set on any cycle where `href`=1 and `vsync`==`V_POL`, in any state except IDLE.
- Errors are sticky until `clr_err` or reset. If `clr_err` coincides with a new error condition, the set wins.
- Simultaneous h_fall and vs_rise on the same edge: the line is counted first, so it is included in `frame_height`.
- Reset mid-frame: all state is discarded and the FSM returns to IDLE. The next frame reported is the first complete frame after the next vs_rise.

## Timing
- Reset values:
  - `frame_done`, `err_*`: 0.
  - `frame_cnt`, `line_width`, `frame_height`, `checksum`: 0.
  - FSM: IDLE.
- All outputs are registered. `frame_done`, the finalized outputs and `err_height` become visible in the cycle after the edge where vs_rise is sampled.
- `line_width`/`err_width` become visible in the cycle after the edge where `href` is first sampled low.
- Continuous stream: `frame_done` period equals the source frame period, H_TOTAL×V_TOTAL cycles.
- No backpressure; the block accepts every cycle.

## Configuration
- `DVP_MON_CHECKSUM_EN` defined:
  - A 32-bit accumulator adds zero-extended `data` on every `href`=1 cycle in ACTIVE, modulo 2^32.
  - The accumulator is latched into `checksum` at finalize.
- Not defined: the accumulator is not built and `checksum` is tied to 32'h0.

## Test plan
- Source with H_DISP=5, V_DISP=5 (22×45 timing), run 3 frames after reset:
  - first `frame_done` occurs exactly 45×22 cycles after the first vs_rise;
  - `frame_cnt`=2 after the 3rd vs_rise;
  - `frame_height`=5, `line_width`=5, all `err_*`=0.
- Source driven with H_DISP=6 against a monitor built with H_DISP=5 → `err_width`=1 after the first line, `line_width`=6; `err_height` stays 0.
- One `href` pulse forced during the `vsync` pulse → `err_sync`=1. Assert `clr_err` → 0 next cycle. Assert `clr_err` on the same cycle as a forced violation → stays 1.
- Pixel data 1..25 ramp with the macro defined → `checksum`=325 at `frame_done`. Without the macro → `checksum`=0.
- `rst_n` low for 1 cycle mid-frame → all outputs 0; the partial frame is not reported; the next `frame_done` comes one full frame after the next vs_rise.
- Final line's h_fall forced on the same edge as vs_rise → `frame_height`=5, no `err_height`.
